// File: rtl/switch_debounce_pkg.sv
// switch_pkg: shared switch-path defaults for the debouncer and the switch read port
package switch_pkg;
  localparam int SW_WIDTH    = 24;
  localparam int SW_TICK_DIV = 23000;
  localparam int SW_STABLE_N = 4;
  typedef logic [SW_WIDTH-1:0] sw_word_t;
endpackage

// File: rtl/switch_debounce_if.sv
// switch_debounce_if: raw switch pins in, debounced levels and strobes out
interface switch_debounce_if import switch_pkg::*; #(
  parameter int WIDTH = SW_WIDTH
);
  logic [WIDTH-1:0] switch_raw;
  logic [WIDTH-1:0] switch_o;
  logic             switch_chg;
  logic             sample_tick;
  modport master (output switch_raw, input switch_o, switch_chg, sample_tick);
  modport slave  (input switch_raw, output switch_o, switch_chg, sample_tick);
endinterface

// File: rtl/switch_debounce_bit.sv
// switch_debounce_bit: one switch line -- 2-flop synchronizer, sample history, debounced output
module switch_debounce_bit import switch_pkg::*; #(
  parameter int STABLE_N = SW_STABLE_N
) (
  input  logic switclk,
  input  logic switrst,
  input  logic sample_tick,
  input  logic raw,
  output logic sw,
  output logic flip
);
  logic                sync1;
  logic                sync2;
  logic [STABLE_N-2:0] hist;
  // the current sample is the STABLE_N-th match when all held samples agree with it
  assign flip = sample_tick && hist == {(STABLE_N-1){sync2}} && sw != sync2;
  // bring the asynchronous pin into the clock domain
  always_ff @(posedge switclk) begin
    sync1 <= switrst ? 1'b0 : raw;
    sync2 <= switrst ? 1'b0 : sync1;
  end
  // shift in one sample per tick; accept the new level once it has been stable long enough
  always_ff @(posedge switclk) begin
    if (switrst) begin
      hist <= '0;
      sw   <= 1'b0;
    end else if (sample_tick) begin
      hist <= (STABLE_N-1)'({hist, sync2});
      sw   <= sw ^ flip;
    end
  end
endmodule

// File: rtl/switch_debounce.sv
// switch_debounce: shared sample prescaler, per-bit debouncers and any-change pulse
module switch_debounce import switch_pkg::*; #(
  parameter int WIDTH    = SW_WIDTH,
  parameter int TICK_DIV = SW_TICK_DIV,
  parameter int STABLE_N = SW_STABLE_N
) (
  input logic               switclk,
  input logic               switrst,
  switch_debounce_if.slave  bus
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0]    cnt;
  logic             tick;
  logic [WIDTH-1:0] sw_q;
  logic [WIDTH-1:0] flip;
  assign tick            = !switrst && cnt == CW'(TICK_DIV-1);
  assign bus.sample_tick = tick;
  assign bus.switch_o    = sw_q;
  // free-running prescaler, wraps straight from TICK_DIV-1 back to 0
  always_ff @(posedge switclk) begin
    cnt <= switrst || tick ? '0 : cnt + 1'b1;
  end
  // one pulse for any number of bits flipping on the same tick
  always_ff @(posedge switclk) begin
    bus.switch_chg <= !switrst && |flip;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(.STABLE_N(STABLE_N)) u_bit (
      .switclk     (switclk),
      .switrst     (switrst),
      .sample_tick (tick),
      .raw         (bus.switch_raw[i]),
      .sw          (sw_q[i]),
      .flip        (flip[i])
    );
  end
endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: directed scenarios with a change-pulse scoreboard
module tb_switch_debounce;
  import switch_pkg::*;
  localparam int TD = 4;
  localparam int SN = 3;
  typedef struct {
    int          cyc;
    logic [23:0] val;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  switch_debounce_if #(.WIDTH(SW_WIDTH)) bus ();
  switch_debounce #(.WIDTH(SW_WIDTH), .TICK_DIV(TD), .STABLE_N(SN)) dut (
    .switclk (clk),
    .switrst (rst),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  // cycle index, 0 = first cycle after reset release
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask
  task automatic do_reset(input logic [23:0] raw);
    bus.switch_raw = raw;
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_switch_o", bus.switch_o, 0);
      chk("rst_switch_chg", bus.switch_chg, 0);
      chk("rst_sample_tick", bus.sample_tick, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  // scoreboard monitor: every change pulse must match the next expected (cycle, value)
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.switch_chg === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL chg_unexpected: got switch_chg=1 switch_o=%h expected no pulse at cycle %0d", bus.switch_o, cyc);
      end else begin
        e = sb.pop_front();
        chk("chg_cycle", cyc, e.cyc);
        chk("chg_value", bus.switch_o, e.val);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.switch_raw = '0;
    // reset values, tick cadence, switches held high through reset release
    do_reset(24'hFFFFFF);
    sb.push_back(exp_t'{12, 24'hFFFFFF});
    for (int c = 0; c < 12; c++) begin
      at_cyc(c);
      chk("tick_cadence", bus.sample_tick, 32'((c % TD) == TD - 1));
    end
    at_cyc(16);
    chk("drain_held", sb.size(), 0);
    // clean single-bit step
    do_reset(24'h000001);
    sb.push_back(exp_t'{12, 24'h000001});
    at_cyc(11);
    chk("step_before", bus.switch_o, 0);
    at_cyc(12);
    chk("step_after", bus.switch_o, 24'h000001);
    at_cyc(16);
    chk("drain_step", sb.size(), 0);
    // bounce on bit 5: toggles every 3 cycles for 40 cycles, then holds 1
    do_reset(24'h000000);
    sb.push_back(exp_t'{52, 24'h000020});
    for (int c = 1; c < 48; c++) begin
      @(posedge clk);
      #1;
      bus.switch_raw[5] = (cyc >= 40) || ((cyc / 3) % 2 == 1);
    end
    at_cyc(48);
    chk("bounce_hold", bus.switch_o, 0);
    at_cyc(51);
    chk("bounce_pre", bus.switch_o, 0);
    at_cyc(52);
    chk("bounce_rise", bus.switch_o, 24'h000020);
    at_cyc(56);
    chk("drain_bounce", sb.size(), 0);
    // multi-bit simultaneous change
    do_reset(24'h000000);
    sb.push_back(exp_t'{16, 24'hA50F3C});
    at_cyc(5);
    bus.switch_raw = 24'hA50F3C;
    at_cyc(15);
    chk("multi_before", bus.switch_o, 0);
    at_cyc(16);
    chk("multi_after", bus.switch_o, 24'hA50F3C);
    at_cyc(20);
    chk("drain_multi", sb.size(), 0);
    // high byte path
    do_reset(24'hC30000);
    sb.push_back(exp_t'{12, 24'hC30000});
    at_cyc(12);
    chk("high_byte", bus.switch_o, 24'hC30000);
    at_cyc(16);
    chk("drain_high", sb.size(), 0);
    // reset one cycle before the 3rd matching tick
    do_reset(24'h000001);
    at_cyc(10);
    chk("mid_before_rst", bus.switch_o, 0);
    do_reset(24'h000001);
    sb.push_back(exp_t'{12, 24'h000001});
    at_cyc(8);
    chk("mid_restart", bus.switch_o, 0);
    at_cyc(11);
    chk("mid_pre", bus.switch_o, 0);
    at_cyc(12);
    chk("mid_after", bus.switch_o, 24'h000001);
    at_cyc(16);
    chk("drain_mid", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
